// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand fetch, issue register and writeback around an
// external combinational ALU. One instruction per cycle, 8x32 register file
// with r0 hardwired to zero, single-level forwarding from the issue slot.
module alu_issue_stage #(
   parameter int unsigned NREG = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [2:0]  in_rd,
   input  logic [2:0]  in_rs1,
   input  logic [2:0]  in_rs2,
   input  logic        in_use_imm,
   input  logic [15:0] in_imm,
   input  logic        stall,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_res,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_v,
   output logic        wb_valid,
   output logic [2:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [3:0]  flags,
   output logic        err,
   input  logic [2:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam logic [3:0] OP_MAX = 4'b0101;

   logic [31:0] rf [NREG];

   logic        iss_valid;
   logic        iss_legal;
   logic [2:0]  iss_rd;

   logic        accept;
   logic        fwd_ok;
   logic        illegal_retire;
   logic [31:0] imm_ext;
   logic [31:0] opa;
   logic [31:0] opb;

   assign in_ready       = ~stall;
   assign accept         = in_valid & ~stall;
   assign fwd_ok         = iss_valid & iss_legal & (iss_rd != 3'd0);
   assign wb_valid       = iss_valid & iss_legal & ~stall;
   assign illegal_retire = iss_valid & ~iss_legal & ~stall;
   assign wb_rd          = iss_rd;
   assign wb_data        = alu_res;
   assign imm_ext        = {{16{in_imm[15]}}, in_imm};
   assign dbg_data       = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

   // Operand selection: r0 reads zero; the instruction in the issue slot
   // retires on the same edge as this accept, so its result is forwarded.
   always_comb begin
      opa = '0;
      opb = '0;
      if (in_rs1 != 3'd0) begin
         if (fwd_ok && (in_rs1 == iss_rd)) opa = alu_res;
         else                              opa = rf[in_rs1];
      end
      if (in_use_imm) begin
         opb = imm_ext;
      end else if (in_rs2 != 3'd0) begin
         if (fwd_ok && (in_rs2 == iss_rd)) opb = alu_res;
         else                              opb = rf[in_rs2];
      end
   end

   // Issue register: load on accept, drop valid when idle, hold on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid <= 1'b0;
         iss_legal <= 1'b0;
         iss_rd    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
      end else if (!stall) begin
         if (accept) begin
            iss_valid <= 1'b1;
            iss_legal <= (in_op <= OP_MAX);
            iss_rd    <= in_rd;
            alu_a     <= opa;
            alu_b     <= opb;
            alu_op    <= in_op;
         end else begin
            iss_valid <= 1'b0;
         end
      end
   end

   // Register file writeback; entry 0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_valid && (iss_rd != 3'd0)) begin
         rf[iss_rd] <= alu_res;
      end
   end

   // Flag register follows every legal writeback, including writes to r0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        flags <= '0;
      else if (wb_valid) flags <= {alu_n, alu_z, alu_c, alu_v};
   end

   // Sticky error on retirement of an illegal opcode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              err <= 1'b0;
      else if (illegal_retire) err <= 1'b1;
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: models the external ALU, drives a directed
// vector table, hand sequences for stall/illegal/reset, then random traffic
// checked against an architectural model with a lagging committed view.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [2:0]  in_rd, in_rs1, in_rs2;
   logic        in_use_imm;
   logic [15:0] in_imm;
   logic        stall;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_res;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic        wb_valid;
   logic [2:0]  wb_rd;
   logic [31:0] wb_data;
   logic [3:0]  flags;
   logic        err;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   alu_issue_stage #(.NREG(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_use_imm(in_use_imm), .in_imm(in_imm), .stall(stall),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags),
      .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // ALU behaviour: returns {res, N, Z, C, V}
   function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic c, v;
      c = 1'b0; v = 1'b0; r = '0;
      case (op)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                     v = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                     v = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd2: r = a | b;
         4'd3: r = a & b;
         4'd4: r = ~(a | b);
         4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: r = '0;
      endcase
      return {r, r[31], (r == 32'd0), c, v};
   endfunction

   logic [35:0] alu_out;
   always_comb begin
      alu_out = alu_fn(alu_a, alu_b, alu_op);
      alu_res = alu_out[35:4];
      {alu_n, alu_z, alu_c, alu_v} = alu_out[3:0];
   end

   int vectors    = 0;
   int miscompares = 0;
   int wb_seen    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: arf = architectural (sequential) state, crf = what
   // has actually been committed; pend_* is the instruction not yet retired.
   logic [31:0] arf [8];
   logic [31:0] crf [8];
   logic [3:0]  cflags;
   logic        cerr;
   logic        pend_v, pend_legal;
   logic [2:0]  pend_rd;
   logic [31:0] pend_res;
   logic [3:0]  pend_fl;
   logic [31:0] ea, eb;
   logic [3:0]  eop;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin arf[i] = '0; crf[i] = '0; end
      cflags = '0; cerr = 1'b0; pend_v = 1'b0; pend_legal = 1'b0;
      pend_rd = '0; pend_res = '0; pend_fl = '0; ea = '0; eb = '0; eop = '0;
   endtask

   task automatic check_outputs();
      logic exp_wbv;
      exp_wbv = pend_v & pend_legal & ~stall;
      if (wb_valid === 1'b1) wb_seen++;
      chk("in_ready", {31'd0, in_ready}, {31'd0, ~stall});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wbv});
      if (exp_wbv) begin
         chk("wb_rd", {29'd0, wb_rd}, {29'd0, pend_rd});
         chk("wb_data", wb_data, pend_res);
      end
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_op", {28'd0, alu_op}, {28'd0, eop});
      chk("dbg_data", dbg_data, crf[dbg_addr]);
      chk("flags", {28'd0, flags}, {28'd0, cflags});
      chk("err", {31'd0, err}, {31'd0, cerr});
   endtask

   task automatic model_edge();
      logic [31:0] a, b;
      logic [35:0] r;
      if (stall) return;
      if (pend_v) begin
         if (pend_legal) begin
            if (pend_rd != 3'd0) crf[pend_rd] = pend_res;
            cflags = pend_fl;
         end else begin
            cerr = 1'b1;
         end
      end
      pend_v = 1'b0;
      if (in_valid) begin
         a = arf[in_rs1];
         b = in_use_imm ? {{16{in_imm[15]}}, in_imm} : arf[in_rs2];
         r = alu_fn(a, b, in_op);
         ea = a; eb = b; eop = in_op;
         pend_v = 1'b1; pend_legal = (in_op <= 4'd5); pend_rd = in_rd;
         pend_res = r[35:4]; pend_fl = r[3:0];
         if (pend_legal && in_rd != 3'd0) arf[in_rd] = pend_res;
      end
   endtask

   task automatic step(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic ui,
                       input logic [15:0] imm, input logic st, input logic [2:0] da);
      @(negedge clk);
      in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_use_imm = ui; in_imm = imm; stall = st; dbg_addr = da;
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input logic st);
      step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0, st, 3'd0);
   endtask

   task automatic check_reset_state();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk("rst_dbg", dbg_data, 32'd0);
      end
      chk("rst_flags", {28'd0, flags}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_alu_a", alu_a, 32'd0);
   endtask

   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0; stall = 1'b0;
      #1;
      check_reset_state();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  rd, rs1, rs2;
      logic        ui;
      logic [15:0] imm;
      logic [31:0] exp_a, exp_b;
      logic        fchk;
      logic [3:0]  exp_flags;
   } row_t;

   row_t rows [9];
   logic [31:0] exp_rf [8];

   initial begin
      // op, rd, rs1, rs2, use_imm, imm, exp_a, exp_b, check flags, flags after this step
      rows[0] = '{4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0001, 32'd0, 32'd1, 1'b0, 4'b0000};
      rows[1] = '{4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0002, 32'd0, 32'd2, 1'b0, 4'b0000};
      rows[2] = '{4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 32'd1, 32'd2, 1'b0, 4'b0000};
      rows[3] = '{4'd1, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0000, 32'd1, 32'd2, 1'b1, 4'b0000};
      rows[4] = '{4'd5, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 32'd1, 32'd2, 1'b1, 4'b1000};
      rows[5] = '{4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'hFFFF, 32'd0, 32'hFFFFFFFF, 1'b1, 4'b0000};
      rows[6] = '{4'd0, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 32'd1, 32'd2, 1'b1, 4'b1000};
      rows[7] = '{4'd0, 3'd7, 3'd0, 3'd0, 1'b0, 16'h0000, 32'd0, 32'd0, 1'b0, 4'b0000};
      rows[8] = '{4'd2, 3'd7, 3'd1, 3'd0, 1'b1, 16'h0004, 32'd1, 32'd4, 1'b0, 4'b0000};
      exp_rf = '{32'd0, 32'd1, 32'd2, 32'd3, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd5};

      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_use_imm = 1'b0; in_imm = '0; stall = 1'b0; dbg_addr = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_state();
      rst_n = 1'b1;

      // Directed table: back-to-back dependent instructions
      for (int i = 0; i < 9; i++) begin
         step(1'b1, rows[i].op, rows[i].rd, rows[i].rs1, rows[i].rs2, rows[i].ui,
              rows[i].imm, 1'b0, 3'(i % 8));
         chk($sformatf("row%0d_alu_a", i), alu_a, rows[i].exp_a);
         chk($sformatf("row%0d_alu_b", i), alu_b, rows[i].exp_b);
         if (rows[i].fchk) chk($sformatf("row%0d_flags", i), {28'd0, flags}, {28'd0, rows[i].exp_flags});
      end
      idle(1'b0);
      idle(1'b0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk($sformatf("table_r%0d", i), dbg_data, exp_rf[i]);
      end

      // Stall: NOR r3 = ~(r1|r2), then hold for three cycles
      step(1'b1, 4'd4, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0, 3'd3);
      wb_seen = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'd0, 3'd5, 3'd6, 3'd6, 1'b0, 16'd0, 1'b1, 3'd3);
         chk("stall_alu_a", alu_a, 32'd1);
         chk("stall_alu_b", alu_b, 32'd2);
         chk("stall_alu_op", {28'd0, alu_op}, 32'd4);
      end
      idle(1'b0);
      idle(1'b0);
      chk("stall_wb_pulses", wb_seen, 32'd1);
      dbg_addr = 3'd3; #1;
      chk("stall_r3", dbg_data, 32'hFFFFFFFC);
      chk("stall_flags", {28'd0, flags}, 32'h8);

      // Illegal opcode targeting r1
      wb_seen = 0;
      step(1'b1, 4'd7, 3'd1, 3'd2, 3'd2, 1'b0, 16'd0, 1'b0, 3'd1);
      idle(1'b0);
      idle(1'b0);
      chk("illegal_err", {31'd0, err}, 32'd1);
      chk("illegal_wb", wb_seen, 32'd0);
      chk("illegal_flags", {28'd0, flags}, 32'h8);
      dbg_addr = 3'd1; #1;
      chk("illegal_r1", dbg_data, 32'd1);
      pulse_reset();

      // Random traffic with a reset while instructions are in flight
      for (int n = 0; n < 400; n++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
         step(($urandom_range(0, 9) < 8), op, 3'($urandom), 3'($urandom), 3'($urandom),
              1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom));
         if (n == 200) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
